// File: rtl/stack_unit_pkg.sv
// Shared definitions for the hardware stack unit.
//   op_e        : decoded stack operation, one per cycle
//   RET_OFFSET  : byte distance from a CALL instruction to its return address
//   encode_op   : fixed-priority strobe encoder (RET > CALL > POP > PUSH)
//   multi_strobe: true when more than one strobe is raised in the same cycle
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_CALL,
    OP_RET
  } op_e;

  localparam int RET_OFFSET = 4;

  function automatic op_e encode_op(input logic push, input logic pop,
                                    input logic call, input logic ret);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (pop)  return OP_POP;
    else if (push) return OP_PUSH;
    else           return OP_NONE;
  endfunction

  function automatic logic multi_strobe(input logic push, input logic pop,
                                        input logic call, input logic ret);
    logic [2:0] n;
    n = {2'b00, push} + {2'b00, pop} + {2'b00, call} + {2'b00, ret};
    return (n > 3'd1);
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Bundle of the stack unit's datapath-facing signals.
//   master : the decoder/writeback side (drives strobes, DATA_IN, PC)
//   slave  : the stack unit itself (drives POP_VAL, RET_ADDR, RD_VALID,
//            SP, EMPTY, FULL, FAULT)
//
// Handshake: there is none. PUSH/POP/CALL/RET are level-sampled on every
// rising clk edge; a strobe held high for k cycles performs k operations.
// RD_VALID is a one-cycle pulse meaning POP_VAL or RET_ADDR was loaded at
// the last edge; the consumer cannot stall it.
interface stack_unit_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic             PUSH;
  logic             POP;
  logic             CALL;
  logic             RET;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] POP_VAL;
  logic [WIDTH-1:0] RET_ADDR;
  logic             RD_VALID;
  logic [SPW-1:0]   SP;
  logic             EMPTY;
  logic             FULL;
  logic             FAULT;

  modport master (
    output PUSH, POP, CALL, RET, DATA_IN, PC,
    input  POP_VAL, RET_ADDR, RD_VALID, SP, EMPTY, FULL, FAULT
  );

  modport slave (
    input  PUSH, POP, CALL, RET, DATA_IN, PC,
    output POP_VAL, RET_ADDR, RD_VALID, SP, EMPTY, FULL, FAULT
  );

endinterface

// File: rtl/stack_unit_ram.sv
// Storage array for the stack: DEPTH x WIDTH entries, one synchronous write
// port and one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index (combinational read)
//   rdata : read data
module stack_ram #(
  parameter int UUID  = 0,
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO for PUSH/POP/CALL/RET. Produces the popped data word
// (POP_VAL) and popped return address (RET_ADDR) for writeback.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; clears SP, flags and outputs
//   sbus : stack_unit_if slave port (strobes, DATA_IN, PC in; results out)
// The stack grows upward: writes go to entry SP, reads come from SP-1.
// The stack state (empty / partial / full) is carried entirely by SP.
module stack_unit
  import stack_pkg::*;
#(
  parameter int    UUID  = 0,
  parameter string NAME  = "",
  parameter int    DEPTH = 16,
  parameter int    WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  sbus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] pop_val_q, pop_val_d;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic             rd_valid_q, rd_valid_d;

  op_e              op;
  logic             multi;
  logic             is_empty;
  logic             is_full;
  logic             ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;

  assign op        = encode_op(sbus.PUSH, sbus.POP, sbus.CALL, sbus.RET);
  assign multi     = multi_strobe(sbus.PUSH, sbus.POP, sbus.CALL, sbus.RET);
  assign is_empty  = (sp_q == '0);
  assign is_full   = (sp_q == SPW'(DEPTH));

  // When full the write index aliases entry 0, but no write is issued then.
  // When empty the read index wraps to DEPTH-1; the read result is replaced
  // by zero in that case.
  assign ram_waddr = sp_q[AW-1:0];
  assign ram_raddr = sp_q[AW-1:0] - AW'(1);

  stack_ram #(
    .UUID  (UUID),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    sp_d       = sp_q;
    fault_d    = fault_q;
    pop_val_d  = pop_val_q;
    ret_addr_d = ret_addr_q;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    // CALL stores the return address; PC+4 wraps modulo 2^WIDTH silently.
    ram_wdata  = (op == OP_CALL) ? (sbus.PC + WIDTH'(RET_OFFSET)) : sbus.DATA_IN;

    unique case (op)
      OP_PUSH, OP_CALL: begin
        if (is_full) begin
          fault_d = 1'b1;
        end else begin
          ram_we = 1'b1;
          sp_d   = sp_q + SPW'(1);
        end
      end
      OP_POP: begin
        rd_valid_d = 1'b1;
        if (is_empty) begin
          pop_val_d = '0;
          fault_d   = 1'b1;
        end else begin
          pop_val_d = ram_rdata;
          sp_d      = sp_q - SPW'(1);
        end
      end
      OP_RET: begin
        rd_valid_d = 1'b1;
        if (is_empty) begin
          ret_addr_d = '0;
          fault_d    = 1'b1;
        end else begin
          ret_addr_d = ram_rdata;
          sp_d       = sp_q - SPW'(1);
        end
      end
      default: ;
    endcase

    // Only the winning strobe executes, but the collision itself is an error.
    if (multi) fault_d = 1'b1;

    empty_d = (sp_d == '0);
    full_d  = (sp_d == SPW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q       <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      fault_q    <= 1'b0;
      pop_val_q  <= '0;
      ret_addr_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      fault_q    <= fault_d;
      pop_val_q  <= pop_val_d;
      ret_addr_q <= ret_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign sbus.SP       = sp_q;
  assign sbus.EMPTY    = empty_q;
  assign sbus.FULL     = full_q;
  assign sbus.FAULT    = fault_q;
  assign sbus.POP_VAL  = pop_val_q;
  assign sbus.RET_ADDR = ret_addr_q;
  assign sbus.RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (DEPTH=16, WIDTH=32). A queue-based
// LIFO reference model predicts every output after each clock edge.
module tb_stack_unit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;

  stack_unit_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) sbus ();

  stack_unit #(
    .UUID  (0),
    .NAME  ("tb_stack"),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sbus (sbus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_pop_val;
  logic [WIDTH-1:0] m_ret_addr;
  logic             m_rd_valid;
  logic             m_fault;

  int n_checks;
  int n_fail;

  task automatic model_reset();
    exp_q.delete();
    m_pop_val  = '0;
    m_ret_addr = '0;
    m_rd_valid = 1'b0;
    m_fault    = 1'b0;
  endtask

  task automatic model_apply(input logic pu, input logic po, input logic ca,
                             input logic re, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] p);
    int n;
    n = int'(pu) + int'(po) + int'(ca) + int'(re);
    if (n > 1) m_fault = 1'b1;
    m_rd_valid = 1'b0;
    if (re) begin
      m_rd_valid = 1'b1;
      if (exp_q.size() == 0) begin
        m_ret_addr = '0;
        m_fault    = 1'b1;
      end else begin
        m_ret_addr = exp_q.pop_back();
      end
    end else if (ca) begin
      if (exp_q.size() == DEPTH) m_fault = 1'b1;
      else exp_q.push_back(p + 32'd4);
    end else if (po) begin
      m_rd_valid = 1'b1;
      if (exp_q.size() == 0) begin
        m_pop_val = '0;
        m_fault   = 1'b1;
      end else begin
        m_pop_val = exp_q.pop_back();
      end
    end else if (pu) begin
      if (exp_q.size() == DEPTH) m_fault = 1'b1;
      else exp_q.push_back(d);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sp"},       32'(sbus.SP),     32'(exp_q.size()));
    chk({tag, ".empty"},    32'(sbus.EMPTY),  32'(exp_q.size() == 0));
    chk({tag, ".full"},     32'(sbus.FULL),   32'(exp_q.size() == DEPTH));
    chk({tag, ".fault"},    32'(sbus.FAULT),  32'(m_fault));
    chk({tag, ".pop_val"},  sbus.POP_VAL,     m_pop_val);
    chk({tag, ".ret_addr"}, sbus.RET_ADDR,    m_ret_addr);
    chk({tag, ".rd_valid"}, 32'(sbus.RD_VALID), 32'(m_rd_valid));
  endtask

  // ---------------- drivers ----------------
  task automatic clear_strobes();
    sbus.PUSH = 1'b0;
    sbus.POP  = 1'b0;
    sbus.CALL = 1'b0;
    sbus.RET  = 1'b0;
  endtask

  task automatic step(input string tag, input logic pu, input logic po,
                      input logic ca, input logic re,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p);
    sbus.PUSH    = pu;
    sbus.POP     = po;
    sbus.CALL    = ca;
    sbus.RET     = re;
    sbus.DATA_IN = d;
    sbus.PC      = p;
    @(posedge clk);
    #1;
    clear_strobes();
    model_apply(pu, po, ca, re, d, p);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic [3:0] strobes);
    sbus.PUSH    = strobes[0];
    sbus.POP     = strobes[1];
    sbus.CALL    = strobes[2];
    sbus.RET     = strobes[3];
    sbus.DATA_IN = $urandom;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_strobes();
    model_reset();
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] d);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, d, '0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic call(input string tag, input logic [WIDTH-1:0] p);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0, '0, p);
  endtask

  task automatic ret(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    sbus.DATA_IN = '0;
    sbus.PC      = '0;
    clear_strobes();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // Push three, pop three.
    push("push_a", 32'hA);
    push("push_b", 32'hB);
    push("push_c", 32'hC);
    pop("pop_1");
    chk("tp_pop_c", sbus.POP_VAL, 32'hC);
    pop("pop_2");
    chk("tp_pop_b", sbus.POP_VAL, 32'hB);
    pop("pop_3");
    chk("tp_pop_a", sbus.POP_VAL, 32'hA);
    step("idle_after_pop", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // CALL/RET round-trip, POP_VAL must hold 0xA.
    call("call_100", 32'h100);
    ret("ret_100");
    chk("tp_ret_104", sbus.RET_ADDR, 32'h104);
    chk("tp_pop_hold", sbus.POP_VAL, 32'hA);

    // PC+4 wrap-around.
    call("call_wrap", 32'hFFFF_FFFC);
    ret("ret_wrap");
    chk("tp_ret_wrap", sbus.RET_ADDR, 32'h0);
    chk("tp_wrap_nofault", 32'(sbus.FAULT), 32'h0);

    // Fill to FULL, then overflow.
    for (int i = 1; i <= DEPTH; i++) push("fill", 32'(i));
    chk("tp_full", 32'(sbus.FULL), 32'h1);
    push("overflow", 32'hDEAD);
    chk("tp_ovf_sp", 32'(sbus.SP), 32'd16);
    chk("tp_ovf_fault", 32'(sbus.FAULT), 32'h1);
    pop("pop_top");
    chk("tp_ovf_top", sbus.POP_VAL, 32'h10);

    // Mid-sequence reset with a strobe asserted discards everything.
    do_reset("reset_mid", 4'b0001);

    // Underflow POP.
    pop("underflow");
    chk("tp_unf_val", sbus.POP_VAL, 32'h0);
    chk("tp_unf_rdv", 32'(sbus.RD_VALID), 32'h1);
    chk("tp_unf_fault", 32'(sbus.FAULT), 32'h1);
    do_reset("reset_clear", 4'b0000);
    chk("tp_fault_clr", 32'(sbus.FAULT), 32'h0);

    // PUSH and RET together: RET wins.
    push("push_40", 32'h40);
    step("push_ret", 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, '0);
    chk("tp_pr_ret", sbus.RET_ADDR, 32'h40);
    chk("tp_pr_sp", 32'(sbus.SP), 32'h0);
    chk("tp_pr_fault", 32'(sbus.FAULT), 32'h1);
    do_reset("reset_pr", 4'b1010);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] p;
      logic [3:0]       s;
      d = $urandom;
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 99) < 2) begin
        s = 4'($urandom_range(0, 15));
        do_reset("rnd_reset", s);
      end else begin
        sel = $urandom_range(0, 19);
        if (sel < 8)       s = 4'b0001;
        else if (sel < 13) s = 4'b0010;
        else if (sel < 15) s = 4'b0100;
        else if (sel < 17) s = 4'b1000;
        else if (sel < 18) s = 4'b0000;
        else               s = 4'($urandom_range(0, 15));
        step("rnd", s[0], s[1], s[2], s[3], d, p);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
